ccff_chain_loader: RTL

- Sequences the configuration flip-flop chain that drives the I/O tiles' GPIO direction bits and the rest of the fabric.
- Accepts bitstream words over a valid/ready stream and serializes them LSB-first onto ccff_head.
- Emits a shift enable for the external prog_clk gate, counts exactly CHAIN_LEN shifts, and returns the previous chain contents, captured from ccff_tail, as readback words.

---
 rtl/ccff_chain_loader.sv | 132 +++++++++++++
 1 files changed

// File: rtl/ccff_chain_loader.sv
// ccff_chain_loader: streams bitstream words LSB-first into the config
// flip-flop chain and returns the displaced chain contents as readback words.
module ccff_chain_loader #(
  parameter int CHAIN_LEN = 16,
  parameter int WORD_W    = 8,
  parameter int CNT_W     = 16
) (
  input  logic              prog_clk,
  input  logic              pReset,
  input  logic              start,
  input  logic [WORD_W-1:0] cfg_data,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  output logic              ccff_head,
  input  logic              ccff_tail,
  output logic              chain_clk_en,
  output logic [WORD_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              busy,
  output logic              done
);

  localparam int BIT_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_FETCH  = 2'd1;
  localparam logic [1:0] S_SHIFT  = 2'd2;
  localparam logic [1:0] S_FINISH = 2'd3;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CHAIN_LEN - 1);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(WORD_W - 1);

  logic [1:0]        r_state;
  logic [1:0]        w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [BIT_W-1:0]  r_bit;
  logic [BIT_W-1:0]  r_cap_idx;
  logic [WORD_W-1:0] r_buf;
  logic [WORD_W-1:0] r_cap;
  logic [WORD_W-1:0] r_rd_data;
  logic              r_rd_valid;

  logic              w_idle;
  logic              w_fetch;
  logic              w_shift;
  logic              w_accept;
  logic              w_last;
  logic              w_wrap;
  logic              w_flush;
  logic [WORD_W-1:0] w_cap_nxt;

  assign w_idle   = (r_state == S_IDLE);
  assign w_fetch  = (r_state == S_FETCH);
  assign w_shift  = (r_state == S_SHIFT);
  assign w_accept = w_fetch & cfg_valid;
  assign w_last   = w_shift & (r_cnt == LAST_CNT);
  assign w_wrap   = w_shift & (r_bit == LAST_BIT);
  // A readback word closes when it is full or when the chain is exhausted.
  assign w_flush  = w_shift
                  & ((r_cap_idx == LAST_BIT) | (r_cnt == LAST_CNT));

  // Merge the pre-edge tail bit into the capture word.
  always_comb begin
    w_cap_nxt = r_cap;
    w_cap_nxt[r_cap_idx] = ccff_tail;
  end

  // Next-state selection; the final shift takes priority over a word wrap.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (start) w_state_nxt = S_FETCH;
      S_FETCH: if (cfg_valid) w_state_nxt = S_SHIFT;
      S_SHIFT: begin
        if (w_last)      w_state_nxt = S_FINISH;
        else if (w_wrap) w_state_nxt = S_FETCH;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge prog_clk) begin
    if (pReset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Counters, word buffer, capture and readback registers.
  always_ff @(posedge prog_clk) begin
    if (pReset) begin
      r_cnt      <= '0;
      r_bit      <= '0;
      r_cap_idx  <= '0;
      r_buf      <= '0;
      r_cap      <= '0;
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= w_flush;
      if (w_idle && start) begin
        r_cnt     <= '0;
        r_cap     <= '0;
        r_cap_idx <= '0;
      end
      if (w_accept) begin
        r_buf <= cfg_data;
        r_bit <= '0;
      end
      if (w_shift) begin
        r_cnt <= r_cnt + CNT_W'(1);
        r_bit <= r_bit + BIT_W'(1);
        if (w_flush) begin
          r_rd_data <= w_cap_nxt;
          r_cap     <= '0;
          r_cap_idx <= '0;
        end else begin
          r_cap     <= w_cap_nxt;
          r_cap_idx <= r_cap_idx + BIT_W'(1);
        end
      end
    end
  end

  assign cfg_ready    = w_fetch;
  assign chain_clk_en = w_shift;
  assign ccff_head    = w_shift ? r_buf[r_bit] : 1'b0;
  assign rd_data      = r_rd_data;
  assign rd_valid     = r_rd_valid;
  assign busy         = w_fetch | w_shift;
  assign done         = (r_state == S_FINISH);

endmodule
